// File: rtl/instr_fetch.sv
// PC owner and instruction fetcher: one registered word read per fetch_en, result latched into instr; waits on imem_ready.
// Optional WAIT-state timeout enabled by defining FETCH_TIMEOUT_EN (fault, no instr_valid, pc unchanged).
module instr_fetch #(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_en,
   input  logic        pc_load,
   input  logic [31:0] pc_next,
   input  logic        fault_clr,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [6:0]  op,
   output logic [31:0] pc,
   output logic [31:0] old_pc,
   output logic        instr_valid,
   output logic        busy,
   output logic        fault
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t      r_state, w_state_nxt;
   logic [31:0] r_pc, w_pc_nxt;
   logic [31:0] r_old_pc, w_old_pc_nxt;
   logic [31:0] r_addr, w_addr_nxt;
   logic [31:0] r_instr, w_instr_nxt;
   logic        r_req, w_req_nxt;
   logic        r_vld, w_vld_nxt;
   logic        r_fault, w_fault_set;
   logic        w_timeout;

`ifdef FETCH_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] r_to_cnt;

   // Counts completed WAIT cycles without ready; IDLE keeps it cleared so every fetch starts at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_to_cnt <= '0;
      else if (r_state == S_IDLE)
         r_to_cnt <= '0;
      else if (!imem_ready)
         r_to_cnt <= r_to_cnt + 16'd1;
   end

   assign w_timeout = (r_state == S_WAIT) && !imem_ready && (r_to_cnt == TO_LAST);
`else
   logic w_unused_cfg;
   assign w_unused_cfg = ^TIMEOUT_CYCLES;
   assign w_timeout    = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_pc_nxt     = r_pc;
      w_old_pc_nxt = r_old_pc;
      w_addr_nxt   = r_addr;
      w_instr_nxt  = r_instr;
      w_req_nxt    = r_req;
      w_vld_nxt    = 1'b0;
      w_fault_set  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (fetch_en) begin
               if (r_pc[1:0] == 2'b00) begin
                  w_req_nxt   = 1'b1;
                  w_addr_nxt  = r_pc;
                  w_state_nxt = S_WAIT;
               end else begin
                  w_fault_set = 1'b1;
               end
            end
         end
         S_WAIT: begin
            if (imem_ready) begin
               w_instr_nxt  = imem_rdata;
               w_old_pc_nxt = r_addr;
               w_pc_nxt     = r_addr + 32'd4;
               w_req_nxt    = 1'b0;
               w_vld_nxt    = 1'b1;
               w_state_nxt  = S_IDLE;
            end else if (w_timeout) begin
               w_req_nxt   = 1'b0;
               w_fault_set = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      // A redirect overrides the sequential +4, but the in-flight address is untouched.
      if (pc_load)
         w_pc_nxt = pc_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc     <= RESET_PC;
         r_old_pc <= RESET_PC;
         r_addr   <= RESET_PC;
         r_instr  <= NOP;
         r_req    <= 1'b0;
         r_vld    <= 1'b0;
         r_fault  <= 1'b0;
      end else begin
         r_pc     <= w_pc_nxt;
         r_old_pc <= w_old_pc_nxt;
         r_addr   <= w_addr_nxt;
         r_instr  <= w_instr_nxt;
         r_req    <= w_req_nxt;
         r_vld    <= w_vld_nxt;
         r_fault  <= w_fault_set | (r_fault & ~fault_clr);
      end
   end

   assign imem_req    = r_req;
   assign imem_addr   = r_addr;
   assign instr       = r_instr;
   assign op          = r_instr[6:0];
   assign pc          = r_pc;
   assign old_pc      = r_old_pc;
   assign instr_valid = r_vld;
   assign busy        = (r_state == S_WAIT);
   assign fault       = r_fault;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized fetch sequences against a queue-based reference model; a monitor checks every instr_valid pulse.
module tb_instr_fetch;

`ifdef FETCH_TIMEOUT_EN
   localparam int unsigned TO_CYC   = 4;
   localparam int          MAX_WAIT = 2;
`else
   localparam int unsigned TO_CYC   = 255;
   localparam int          MAX_WAIT = 3;
`endif
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fetch_en = 1'b0, pc_load = 1'b0, fault_clr = 1'b0, imem_ready = 1'b0;
   logic [31:0] pc_next = '0, imem_rdata = '0;
   logic        imem_req, instr_valid, busy, fault;
   logic [31:0] imem_addr, instr, pc, old_pc;
   logic [6:0]  op;

   instr_fetch #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(TO_CYC)) dut (
      .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .pc_load(pc_load), .pc_next(pc_next),
      .fault_clr(fault_clr), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rdata(imem_rdata), .instr(instr), .op(op), .pc(pc), .old_pc(old_pc),
      .instr_valid(instr_valid), .busy(busy), .fault(fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] old_pc;
      logic [31:0] pc;
   } exp_t;

   exp_t        exp_q[$];
   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] model_pc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: each instr_valid pulse must match the oldest outstanding fetch.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && instr_valid) begin
            if (exp_q.size() == 0) begin
               chk("spurious_valid", {31'd0, instr_valid}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("instr", instr, e.instr);
               chk("op", {25'd0, op}, {25'd0, e.instr[6:0]});
               chk("old_pc", old_pc, e.old_pc);
               chk("pc_after", pc, e.pc);
            end
         end
      end
   end

   function automatic logic [31:0] rand_aligned();
      logic [31:0] t;
      t = $urandom;
      t[1:0] = 2'b00;
      return t;
   endfunction

   task automatic do_load(input logic [31:0] v);
      pc_load = 1'b1;
      pc_next = v;
      @(negedge clk);
      pc_load = 1'b0;
      chk("pc_load", pc, v);
      model_pc = v;
   endtask

   task automatic do_fetch(input int nwait, input logic [31:0] data, input bit ld, input logic [31:0] ld_val,
                           input bit noise);
      logic [31:0] a;
      logic [31:0] mid_val;
      bit          mid_pend;
      exp_t        e;
      a        = model_pc;
      mid_pend = 1'b0;
      mid_val  = '0;
      chk("pc_pre", pc, model_pc);
      fetch_en = 1'b1;
      e.instr  = data;
      e.old_pc = a;
      e.pc     = ld ? ld_val : a + 32'd4;
      exp_q.push_back(e);
      @(negedge clk);
      fetch_en = 1'b0;
      for (int i = 0; i < nwait; i++) begin
         chk("wait_req", {31'd0, imem_req}, 32'd1);
         chk("wait_busy", {31'd0, busy}, 32'd1);
         chk("wait_addr", imem_addr, a);
         if (mid_pend) chk("mid_pc_load", pc, mid_val);
         mid_pend = 1'b0;
         pc_load  = 1'b0;
         if (noise) begin
            fetch_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) begin
               pc_load  = 1'b1;
               mid_val  = $urandom;
               pc_next  = mid_val;
               mid_pend = 1'b1;
            end
         end
         @(negedge clk);
      end
      chk("last_req", {31'd0, imem_req}, 32'd1);
      chk("last_busy", {31'd0, busy}, 32'd1);
      chk("last_addr", imem_addr, a);
      if (mid_pend) chk("mid_pc_load", pc, mid_val);
      fetch_en   = 1'b0;
      imem_ready = 1'b1;
      imem_rdata = data;
      pc_load    = ld;
      pc_next    = ld_val;
      @(negedge clk);
      imem_ready = 1'b0;
      pc_load    = 1'b0;
      imem_rdata = $urandom;
      chk("done_req", {31'd0, imem_req}, 32'd0);
      chk("done_busy", {31'd0, busy}, 32'd0);
      model_pc = ld ? ld_val : a + 32'd4;
   endtask

   task automatic do_misfetch(input bit clr_same);
      chk("pc_pre_mis", pc, model_pc);
      fetch_en  = 1'b1;
      fault_clr = clr_same;
      @(negedge clk);
      fetch_en  = 1'b0;
      fault_clr = 1'b0;
      chk("mis_req", {31'd0, imem_req}, 32'd0);
      chk("mis_busy", {31'd0, busy}, 32'd0);
      chk("mis_fault", {31'd0, fault}, 32'd1);
      fault_clr = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0;
      chk("fault_clr", {31'd0, fault}, 32'd0);
   endtask

   task automatic idle_noise();
      imem_ready = 1'b1;
      imem_rdata = $urandom;
      @(negedge clk);
      imem_ready = 1'b0;
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_pc", pc, model_pc);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] v;
      repeat (3) @(negedge clk);
      chk("rst_pc", pc, RST_PC);
      chk("rst_old_pc", old_pc, RST_PC);
      chk("rst_addr", imem_addr, RST_PC);
      chk("rst_instr", instr, 32'h0000_0013);
      chk("rst_op", {25'd0, op}, 32'h13);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_fault", {31'd0, fault}, 32'd0);
      rst_n    = 1'b1;
      model_pc = RST_PC;
      @(negedge clk);

      do_fetch(0, 32'h0050_0093, 1'b0, 32'd0, 1'b0);
      do_fetch(MAX_WAIT, 32'h0000_0033, 1'b0, 32'd0, 1'b0);
      do_fetch(1, 32'h0010_0113, 1'b1, 32'h0000_0100, 1'b0);
      do_fetch(0, 32'h0020_0193, 1'b0, 32'd0, 1'b0);
      do_load(32'h0000_0102);
      do_misfetch(1'b0);
      do_misfetch(1'b1);
      do_load(32'h0000_0200);

      // Reset during WAIT, with a late ready that must be ignored.
      fetch_en = 1'b1;
      @(negedge clk);
      fetch_en = 1'b0;
      chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_req", {31'd0, imem_req}, 32'd0);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      imem_ready = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      imem_ready = 1'b0;
      @(negedge clk);
      chk("post_rst_instr", instr, 32'h0000_0013);
      chk("post_rst_pc", pc, RST_PC);
      chk("post_rst_req", {31'd0, imem_req}, 32'd0);
      chk("post_rst_valid", {31'd0, instr_valid}, 32'd0);
      model_pc = RST_PC;

`ifdef FETCH_TIMEOUT_EN
      fetch_en = 1'b1;
      @(negedge clk);
      fetch_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("to_busy", {31'd0, busy}, 32'd1);
         chk("to_req", {31'd0, imem_req}, 32'd1);
         @(negedge clk);
      end
      chk("to_done_busy", {31'd0, busy}, 32'd0);
      chk("to_done_req", {31'd0, imem_req}, 32'd0);
      chk("to_fault", {31'd0, fault}, 32'd1);
      chk("to_pc", pc, model_pc);
      fault_clr = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0;
`endif

      for (int n = 0; n < 150; n++) begin
         if (model_pc[1:0] != 2'b00) begin
            do_misfetch(1'($urandom_range(0, 1)));
            do_load(rand_aligned());
         end else if ($urandom_range(0, 9) == 0) begin
            v = $urandom;
            if (v[1:0] == 2'b00) v[0] = 1'b1;
            do_load(v);
         end else begin
            if ($urandom_range(0, 3) == 0) v = ($urandom_range(0, 7) == 0) ? $urandom : rand_aligned();
            else v = '0;
            do_fetch($urandom_range(0, MAX_WAIT), $urandom, v != 32'd0, v, 1'b1);
         end
         if ($urandom_range(0, 3) == 0) idle_noise();
      end

      repeat (3) @(negedge clk);
      chk("queue_drain", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
